// File: rtl/blink_stream_shim.sv
// rtl/blink_stream_shim.sv - word-serial load/drain shim around the registered Blink cipher wrapper
module blink_stream_shim #(
    parameter int W   = 32,
    parameter int N   = 128,
    parameter int TW  = 256,
    parameter int KW  = 1024,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_sel,
    input  logic [W-1:0]  in_data,
    output logic          enc,
    output logic [KW-1:0] K0,
    output logic [TW-1:0] T,
    output logic [N-1:0]  P,
    input  logic [N-1:0]  C_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic          busy,
    output logic          err
);

    localparam int KWORDS = KW / W;
    localparam int TWORDS = TW / W;
    localparam int NWORDS = N / W;
    localparam int KCW    = $clog2(KWORDS + 1);
    localparam int TCW    = $clog2(TWORDS + 1);
    localparam int PCW    = $clog2(NWORDS + 1);
    localparam int WCW    = $clog2(LAT + 1);

    localparam logic [KCW-1:0] KFULL = KCW'(KWORDS);
    localparam logic [TCW-1:0] TFULL = TCW'(TWORDS);
    localparam logic [PCW-1:0] PFULL = PCW'(NWORDS);
    localparam logic [PCW-1:0] OLAST = PCW'(NWORDS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]     state;
    logic [KW-1:0]  kbuf;
    logic [TW-1:0]  tbuf;
    logic [N-1:0]   pbuf;
    logic [N-1:0]   obuf;
    logic [KCW-1:0] kcnt;
    logic [TCW-1:0] tcnt;
    logic [PCW-1:0] pcnt;
    logic [PCW-1:0] ocnt;
    logic [WCW-1:0] wcnt;
    logic           all_full;

    assign all_full  = (kcnt == KFULL) && (tcnt == TFULL) && (pcnt == PFULL);
    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DRAIN);
    assign out_last  = (state == S_DRAIN) && (ocnt == OLAST);
    assign out_data  = obuf[W-1:0];
    assign K0        = kbuf;
    assign T         = tbuf;
    assign P         = pbuf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            kbuf  <= '0;
            tbuf  <= '0;
            pbuf  <= '0;
            obuf  <= '0;
            kcnt  <= '0;
            tcnt  <= '0;
            pcnt  <= '0;
            ocnt  <= '0;
            wcnt  <= '0;
            enc   <= 1'b0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Shift-in from the top so word 0 ends up in the low bits once full
                        case (in_sel)
                            2'd0: begin
                                kbuf <= {in_data, kbuf[KW-1:W]};
                                if (kcnt != KFULL) kcnt <= kcnt + KCW'(1);
                            end
                            2'd1: begin
                                tbuf <= {in_data, tbuf[TW-1:W]};
                                if (tcnt != TFULL) tcnt <= tcnt + TCW'(1);
                            end
                            2'd2: begin
                                pbuf <= {in_data, pbuf[N-1:W]};
                                if (pcnt != PFULL) pcnt <= pcnt + PCW'(1);
                            end
                            default: begin
                                if (all_full) begin
                                    enc   <= in_data[0];
                                    wcnt  <= WCW'(LAT);
                                    pcnt  <= '0;
                                    state <= S_WAIT;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                S_WAIT: begin
                    if (wcnt == '0) begin
                        obuf  <= C_in;
                        ocnt  <= '0;
                        state <= S_DRAIN;
                    end else begin
                        wcnt <= wcnt - WCW'(1);
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        obuf <= {{W{1'b0}}, obuf[N-1:W]};
                        if (ocnt == OLAST) begin
                            ocnt  <= '0;
                            state <= S_IDLE;
                        end else begin
                            ocnt <= ocnt + PCW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blink_stream_shim.sv
// tb/tb_blink_stream_shim.sv - directed bench for blink_stream_shim with a two-stage stand-in cipher
module tb_blink_stream_shim;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_sel = 2'd0;
    logic [31:0]   in_data = '0;
    logic          enc;
    logic [1023:0] K0;
    logic [255:0]  T;
    logic [127:0]  P;
    logic [127:0]  C_in;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_data;
    logic          out_last;
    logic          busy;
    logic          err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    blink_stream_shim dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .enc(enc), .K0(K0), .T(T), .P(P), .C_in(C_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .err(err)
    );

    // Invertible stand-in for the cipher: enc = rotl5(p^k^t), dec = rotr5(c)^k^t
    function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k,
                                           input logic [127:0] t, input logic e);
        logic [127:0] x;
        if (e) begin
            x = d ^ k ^ t;
            return {x[122:0], x[127:123]};
        end
        x = {d[4:0], d[127:5]};
        return x ^ k ^ t;
    endfunction

    logic [127:0] s1_p, s1_k, s1_t, c_reg;
    logic         s1_e;
    always @(posedge clk) begin
        s1_p  <= P;
        s1_k  <= K0[127:0];
        s1_t  <= T[127:0];
        s1_e  <= enc;
        c_reg <= model(s1_p, s1_k, s1_t, s1_e);
    end
    assign C_in = c_reg;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [31:0] data);
        if (in_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL send_ready: got %b expected 1", in_ready);
        end
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [1:0] sel, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) send(sel, base + 32'(i));
    endtask

    task automatic drain(input logic [127:0] exp, input bit stall);
        for (int w = 0; w < 4; w++) begin
            chk("drain_valid", 128'(out_valid), 128'(1));
            chk("drain_data", 128'(out_data), 128'(exp[32*w +: 32]));
            chk("drain_last", 128'(out_last), 128'(w == 3));
            if (stall && w == 1) begin
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    chk("stall_valid", 128'(out_valid), 128'(1));
                    chk("stall_data", 128'(out_data), 128'(exp[63:32]));
                end
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
        chk("post_drain_valid", 128'(out_valid), 128'(0));
        chk("post_drain_busy", 128'(busy), 128'(0));
        chk("post_drain_ready", 128'(in_ready), 128'(1));
    endtask

    typedef struct {
        int          nk;
        int          nt;
        int          np;
        logic        exp_err;
        logic [31:0] k_lo;
        logic [31:0] k_hi;
    } vec_t;

    vec_t vecs[9];

    logic [127:0] kv, tv, pv, c1;

    initial begin
        vecs[0] = '{32, 8, 0, 1'b1, 32'd0,  32'd31};
        vecs[1] = '{32, 0, 4, 1'b1, 32'd0,  32'd31};
        vecs[2] = '{0,  8, 4, 1'b1, 32'd0,  32'd0};
        vecs[3] = '{31, 8, 4, 1'b1, 32'd0,  32'd30};
        vecs[4] = '{32, 8, 3, 1'b1, 32'd0,  32'd31};
        vecs[5] = '{32, 8, 4, 1'b0, 32'd0,  32'd31};
        vecs[6] = '{33, 8, 4, 1'b0, 32'd1,  32'd32};
        vecs[7] = '{40, 9, 5, 1'b0, 32'd8,  32'd39};
        vecs[8] = '{0,  0, 0, 1'b1, 32'd0,  32'd0};

        kv = {32'd3, 32'd2, 32'd1, 32'd0};
        tv = {32'h103, 32'h102, 32'h101, 32'h100};
        pv = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        c1 = model(pv, kv, tv, 1'b1);

        // reset state, sampled while reset is held
        #2;
        chk("rst_ready", 128'(in_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_last", 128'(out_last), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_enc", 128'(enc), 128'(0));
        chk("rst_k0", 128'(|K0), 128'(0));
        chk("rst_t", 128'(|T), 128'(0));
        chk("rst_p", P, 128'(0));
        chk("rst_data", 128'(out_data), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;

        // go acceptance against load counts, including saturation
        for (int v = 0; v < 9; v++) begin
            do_reset();
            load(2'd0, vecs[v].nk, 32'd0);
            load(2'd1, vecs[v].nt, 32'h100);
            load(2'd2, vecs[v].np, 32'hA0);
            chk($sformatf("v%0d_k_lo", v), 128'(K0[31:0]), 128'(vecs[v].k_lo));
            chk($sformatf("v%0d_k_hi", v), 128'(K0[1023:992]), 128'(vecs[v].k_hi));
            send(2'd3, 32'd1);
            chk($sformatf("v%0d_err", v), 128'(err), 128'(vecs[v].exp_err));
            chk($sformatf("v%0d_busy", v), 128'(busy), 128'(!vecs[v].exp_err));
            chk($sformatf("v%0d_ready", v), 128'(in_ready), 128'(vecs[v].exp_err));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_err_pulse", v), 128'(err), 128'(0));
            chk($sformatf("v%0d_no_valid", v), 128'(out_valid), 128'(0));
        end

        // block 1: full load, encrypt, latency, stalled drain
        do_reset();
        load(2'd0, 32, 32'd0);
        load(2'd1, 8, 32'h100);
        load(2'd2, 4, 32'hA0);
        chk("b1_k0_lo", 128'(K0[31:0]), 128'(0));
        chk("b1_k0_hi", 128'(K0[1023:992]), 128'(31));
        chk("b1_p", P, pv);
        send(2'd3, 32'd1);
        chk("b1_enc", 128'(enc), 128'(1));
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b1_lat%0d", i), 128'(out_valid), 128'(i == 3));
            chk($sformatf("b1_ready%0d", i), 128'(in_ready), 128'(0));
        end
        drain(c1, 1'b1);

        // block 2: plaintext only, decrypt the first ciphertext
        load(2'd2, 4, 32'd0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_sel   = 2'd2;
            in_data  = c1[32*i +: 32];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("b2_p", P, c1);
        send(2'd3, 32'd0);
        chk("b2_err", 128'(err), 128'(0));
        chk("b2_busy", 128'(busy), 128'(1));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        drain(pv, 1'b0);

        // reset one cycle into WAIT aborts the block
        load(2'd2, 4, 32'hA0);
        send(2'd3, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_enc", 128'(enc), 128'(0));
        chk("abort_k0", 128'(|K0), 128'(0));
        chk("abort_p", P, 128'(0));
        chk("abort_valid", 128'(out_valid), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("abort_idle_valid", 128'(out_valid), 128'(0));
        end
        chk("abort_ready", 128'(in_ready), 128'(1));
        send(2'd3, 32'd1);
        chk("abort_go_err", 128'(err), 128'(1));
        chk("abort_go_busy", 128'(busy), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/blink_stream_shim.md
Name: blink_stream_shim

Overview:
- Word-serial front/back end for the registered Blink cipher wrapper (128-bit block, 256-bit tweak, 1024-bit round-key bundle).
- Collects key, tweak and plaintext from a narrow valid/ready command stream and drives them as stable wide buses into the cipher wrapper.
- Waits out the wrapper's fixed pipeline latency, captures the ciphertext and streams it back out word by word.
- Sits directly upstream of the cipher wrapper, and directly downstream of it for the result.

Parameters:
- W, 32, stream word width
- N, 128, block width
- TW, 256, tweak width
- KW, 1024, key bundle width (8 x 128)
- LAT, 2, cipher wrapper latency in clocks (input register + output register)
- Constraint: N, TW and KW must each be a multiple of W.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  command word valid
- in_ready  out  1  shim accepts command word
- in_sel  in  2  destination: 0=key, 1=tweak, 2=plaintext, 3=go
- in_data  in  W  payload; for go, bit0 = enc
- enc  out  1  to cipher wrapper enc
- K0  out  KW  to cipher wrapper K0
- T  out  TW  to cipher wrapper T
- P  out  N  to cipher wrapper P
- C_in  in  N  from cipher wrapper C
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts result word
- out_data  out  W  result word
- out_last  out  1  final result word of block
- busy  out  1  high whenever state is not IDLE
- err  out  1  one-cycle pulse when a go is rejected

Behaviour:
- Reset (async, rst=0): state IDLE; all buffers, counters and outputs are 0 (K0, T, P, enc, out_data, out_valid, out_last, err, busy). in_ready is 1 after reset releases.
- Word counters: kcnt saturates at KW/W, tcnt at TW/W, pcnt at N/W.
- States: IDLE, WAIT, DRAIN.
- IDLE:
  - in_ready=1; a word is accepted when in_valid=1.
  - Accepting sel 0/1/2: the target buffer shifts right by W and in_data enters the top W bits. After a full load, word 0 therefore sits at bits [W-1:0]. The matching counter increments, saturating.
  - Extra words beyond full keep shifting; the buffer holds the last KW/W, TW/W or N/W words and the counter stays saturated.
- Go (sel 3):
  - Accepted only if kcnt, tcnt and pcnt are all full. Then enc <= in_data[0], wcnt <= LAT, pcnt <= 0, and the next state is WAIT.
  - Rejected otherwise: the word is consumed (handshake completes), err pulses high for exactly one cycle, state stays IDLE, and no buffer changes.
- WAIT:
  - in_ready=0; K0, T, P and enc are held stable.
  - wcnt decrements each clock. On the clock where wcnt==0, C_in is captured into the output shift register and the state moves to DRAIN.
  - Net effect: capture occurs on the (LAT+1)th rising edge after go acceptance.
- DRAIN:
  - in_ready=0; out_valid=1; out_data = obuf[W-1:0].
  - Each out_valid&out_ready cycle shifts obuf right by W and increments ocnt.
  - out_last=1 when ocnt==N/W-1.
  - A handshake while out_last=1 returns to IDLE in the next cycle with out_valid=0 and ocnt=0.
  - With out_ready=0, out_data and out_last hold.
- Key and tweak persist across blocks; only the plaintext must be reloaded for each block.
- K0, T and P are continuous views of the buffers. They may change during IDLE loading; the cipher result is meaningful only after a go.
- Command input and result output are never open simultaneously. A go is never accepted while DRAIN is active.
- Reset asserted mid-WAIT or mid-DRAIN aborts the block immediately: all outputs return to reset values and the partial result is discarded.

Test Plan:
- Load 32 key words k_i=i, 8 tweak words 0x100+i, 4 plaintext words 0xA0+i, then go with enc=1 -> K0[31:0]=0, K0[1023:992]=31, P=0x000000A3_000000A2_000000A1_000000A0. out_valid rises 3 clocks after go acceptance. 4 words equal to C_in[31:0]..[127:96] from a behavioural Blink model; out_last on word 4 only.
- After reset, load key and tweak only, then go -> err high exactly 1 cycle, busy stays 0, in_ready stays 1, no out_valid.
- During DRAIN, hold out_ready=0 for 5 cycles after word 1 -> out_data and out_valid stable; words still arrive in order with no loss or duplication.
- Second block loads only 4 new plaintext words, then go with enc=0 -> accepted (key and tweak retained). Decryption output matches the first block's plaintext when fed the first block's ciphertext.
- Load 33 key words 0..32 -> K0[31:0]=1, K0[1023:992]=32, kcnt saturated, go accepted.
- Assert rst=0 one cycle into WAIT -> outputs zero asynchronously. After release: IDLE, in_ready=1, and a go without reload triggers err.
